// File: rtl/avr_dmem_arbiter_if.sv
// Data-memory bus bundle: CPU data port, secondary (DMA/debug) port and the
// single-port SRAM port, all seen through one arbiter.
interface avr_dmem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_hold;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic [DW-1:0] dma_rdata;
    logic          dma_rvalid;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_hold,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // requesters + SRAM side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_hold,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/avr_dmem_arbiter.sv
// Shares the single-port data SRAM between the CPU (fixed priority) and a
// DMA/debug port. A starvation counter forces one DMA slot after MAX_WAIT
// denied cycles; read data returns one cycle after grant to its owner.
module avr_dmem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    avr_dmem_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} own_e;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0]    wait_cnt_q, wait_cnt_d;
    own_e          rd_owner_q, rd_owner_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          dma_sel;
    logic          cpu_sel;

    // Grant decision; reset forces every grant off so nothing reaches the SRAM
    always_comb begin
        dma_sel = RST_N & bus.dma_req & (~bus.cpu_req | (wait_cnt_q == WAIT_MAX));
        cpu_sel = RST_N & bus.cpu_req & ~dma_sel;
    end

    // SRAM port mux: the granted requester drives it, otherwise all zero
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (dma_sel) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.dma_we;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end else if (cpu_sel) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end
    end

    assign bus.dma_gnt  = dma_sel;
    assign bus.cpu_hold = bus.cpu_req & dma_sel;

    // Return path: DMA data only on its valid pulse; CPU data held between reads
    assign bus.dma_rvalid = (rd_owner_q == OWN_DMA);
    assign bus.dma_rdata  = (rd_owner_q == OWN_DMA) ? bus.mem_rdata : '0;
    assign bus.cpu_rdata  = (rd_owner_q == OWN_CPU) ? bus.mem_rdata : cpu_rdata_q;

    // Next-state: starvation count, owner of the in-flight read, CPU data capture
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        rd_owner_d  = OWN_NONE;
        cpu_rdata_d = cpu_rdata_q;

        // a grant or a dropped request restarts the count; otherwise saturate
        if (dma_sel || !bus.dma_req)
            wait_cnt_d = '0;
        else if (wait_cnt_q != WAIT_MAX)
            wait_cnt_d = wait_cnt_q + 4'd1;

        if (dma_sel && !bus.dma_we)
            rd_owner_d = OWN_DMA;
        else if (cpu_sel && !bus.cpu_we)
            rd_owner_d = OWN_CPU;

        if (rd_owner_q == OWN_CPU)
            cpu_rdata_d = bus.mem_rdata;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wait_cnt_q  <= '0;
            rd_owner_q  <= OWN_NONE;
            cpu_rdata_q <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            rd_owner_q  <= rd_owner_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end
endmodule

// File: doc/avr_dmem_arbiter.md
# avr_dmem_arbiter

Two-port arbiter that shares the single-port synchronous data SRAM between the `avr_cpu` data port and a secondary requester (DMA / debug port). The CPU has fixed priority. A starvation counter forces one DMA slot after `MAX_WAIT` denied cycles; during that slot the CPU is held through `cpu_hold`, which is ORed into the fetch-stage `stall`. Read data is returned one cycle after grant, steered to the owner of the access.

## Interface
- `AW`, 16, address width (matches `d_addr`)
- `DW`, 8, data width
- `MAX_WAIT`, 4, denied DMA cycles before a forced DMA slot; legal range 1–15
- `CLK`  in  1  system clock
- `RST_N`  in  1  reset; synchronous and active-low
- `cpu_req`  in  1  CPU data access this cycle
- `cpu_we`  in  1  CPU write strobe (`data_write`)
- `cpu_addr`  in  AW  CPU address (`d_addr`)
- `cpu_wdata`  in  DW  CPU write data (`data_out`)
- `cpu_rdata`  out  DW  read data to CPU (`data_in`)
- `cpu_hold`  out  1  CPU access denied this cycle; CPU must repeat it
- `dma_req`  in  1  DMA request; held until granted
- `dma_we`  in  1  DMA write
- `dma_addr`  in  AW  DMA address
- `dma_wdata`  in  DW  DMA write data
- `dma_gnt`  out  1  DMA access performed this cycle
- `dma_rdata`  out  DW  DMA read data
- `dma_rvalid`  out  1  `dma_rdata` valid
- `mem_en`, `mem_we`  out  1  SRAM enable and write
- `mem_addr`  out  AW  SRAM address
- `mem_wdata`  out  DW  SRAM write data
- `mem_rdata`  in  DW  SRAM read data, valid the cycle after `mem_en & ~mem_we`

## Operation
- **Grant decision.** Combinational, every cycle:
  - `dma_sel = dma_req & (~cpu_req | wait_cnt == MAX_WAIT)`
  - `cpu_sel = cpu_req & ~dma_sel`
- **Memory outputs.**
  - If `dma_sel`: the mem port carries the `dma_*` fields.
  - Else if `cpu_sel`: the mem port carries the `cpu_*` fields.
  - Otherwise `mem_en = mem_we = 0` and `mem_addr = mem_wdata = 0`.
- **Handshake outputs.**
  - `dma_gnt = dma_sel`
  - `cpu_hold = cpu_req & dma_sel`
- **Starvation counter** `wait_cnt` (4 bits):
  - increments when `dma_req & ~dma_sel`, saturating at `MAX_WAIT`
  - clears when `dma_sel` or `~dma_req`
  - A forced slot clears the counter, so the CPU then owns the next `MAX_WAIT` contended cycles.
- **Read steering.** A registered `rd_owner` takes one of three states: `NONE`, `CPU`, `DMA`.
  - Set to `CPU` on a CPU read grant, `DMA` on a DMA read grant, `NONE` otherwise.
  - `dma_rvalid = (rd_owner == DMA)`
  - `dma_rdata = mem_rdata` when valid, else 0.
  - `cpu_rdata = mem_rdata` when `rd_owner == CPU`, else holds its last CPU value (registered capture), so POP sees stable data.
- **DMA rules.**
  - `dma_addr`, `dma_we` and `dma_wdata` stay stable from the rise of `dma_req` until `dma_gnt`.
  - Deasserting `dma_req` before grant aborts the request with no memory effect and clears `wait_cnt`.
  - Back-to-back DMA requests are legal: one access per cycle while the CPU is idle.
- **CPU rules.**
  - While `cpu_hold` is 1, no CPU memory effect occurs.
  - The CPU re-presents the same access the next cycle; the arbiter keeps no CPU queue.

## Timing
- Grant and mem outputs are combinational from the request inputs: 0-cycle request-to-SRAM.
- Read data arrives at cycle N+1 for a grant at cycle N. `dma_rvalid` is a 1-cycle pulse at N+1.
- Under continuous CPU traffic with `MAX_WAIT = 4`:
  - `dma_req` rising at cycle 0 is granted at cycle 4.
  - `cpu_hold` is high at cycle 4 only.
  - The next forced slot comes no earlier than cycle 9.
- Write-then-read to the same address on consecutive cycles returns the new data (SRAM write-first, no arbiter bypass).
- **Reset** (`RST_N = 0` at a clock edge):
  - `wait_cnt = 0`, `rd_owner = NONE`, `cpu_rdata = 0`
  - `dma_rvalid = 0` from the next cycle, `dma_rdata = 0`
  - While `RST_N` is low, grants are forced off: `mem_en = 0`, `dma_gnt = 0`, `cpu_hold = 0`.
- **Reset mid-operation.** A read granted in the reset cycle is discarded: no `dma_rvalid`, and `cpu_rdata` is 0.

## Test plan
- **Reset.** Drive `RST_N = 0` for 2 cycles with both requests high → `mem_en = 0`, `dma_gnt = 0`, `cpu_hold = 0`, `dma_rvalid = 0`, `cpu_rdata = 0`.
- **DMA idle path.** CPU idle; DMA writes 0x5A to 0x0100, then reads 0x0100 → `dma_gnt` for 1 cycle each; `dma_rvalid` 1 cycle after the read grant with `dma_rdata = 0x5A`.
- **Starvation.** `cpu_req` held high with reads of 0x0200; `dma_req` high from cycle 0 with a write of 0x33 to 0x0300 → `dma_gnt` and `cpu_hold` only at cycle 4; `wait_cnt` 0,1,2,3,4 then 0; a second request pending is granted at cycle 9.
- **Read steering.** Alternate a CPU read of 0x0010 (contains 0x11) and a DMA read of 0x0020 (contains 0x22) while the CPU is idle on the DMA cycle → `cpu_rdata = 0x11` held stable; `dma_rvalid` only on the DMA return, with `0x22`.
- **Abort.** `dma_req` high for 2 denied cycles, then dropped → no DMA memory write; `wait_cnt` returns to 0; no `cpu_hold`.
- **Reset mid-read.** DMA read granted at cycle N with `RST_N = 0` at the edge ending N → `dma_rvalid = 0` at N+1; memory unchanged.
